// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one external memory port between the I-cache refill
// path and the data-memory path, with a timeout abort for hung transactions.
// Optional feature: define ARBITER_RR_EN for round-robin on simultaneous
// requests; when undefined, D wins every tie and no last-grant state exists.
module imem_dmem_arbiter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_ic_req,
    input  logic [XLEN-1:0]     i_ic_addr,
    output logic                o_ic_ready,
    output logic [XLEN-1:0]     o_ic_data,
    output logic                o_ic_err,
    input  logic                i_dm_req,
    input  logic                i_dm_we,
    input  logic [XLEN-1:0]     i_dm_addr,
    input  logic [XLEN-1:0]     i_dm_wdata,
    input  logic [XLEN/8-1:0]   i_dm_be,
    output logic                o_dm_ready,
    output logic [XLEN-1:0]     o_dm_rdata,
    output logic                o_dm_err,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [XLEN-1:0]     o_mem_addr,
    output logic [XLEN-1:0]     o_mem_wdata,
    output logic [XLEN/8-1:0]   o_mem_be,
    input  logic                i_mem_ack,
    input  logic [XLEN-1:0]     i_mem_rdata
);

    localparam int unsigned BE_W       = XLEN / 8;
    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;

    logic               any_req_c;
    logic               pick_d_c;
    logic               tie_pick_d_c;
    logic               timeout_c;

    logic               mem_req_d;
    logic               mem_we_d;
    logic [XLEN-1:0]    mem_addr_d;
    logic [XLEN-1:0]    mem_wdata_d;
    logic [BE_W-1:0]    mem_be_d;
    logic               ic_ready_d;
    logic [XLEN-1:0]    ic_data_d;
    logic               ic_err_d;
    logic               dm_ready_d;
    logic [XLEN-1:0]    dm_rdata_d;
    logic               dm_err_d;

    assign any_req_c = i_ic_req | i_dm_req;
    // The grant cycle in which the counter sits at TIMEOUT_CYCLES-1 is the last one allowed.
    assign timeout_c = TIMEOUT_EN && (cnt_q == CNT_LAST);

`ifdef ARBITER_RR_EN
    logic last_d_q;

    assign tie_pick_d_c = ~last_d_q;

    // Remember which side won the most recent grant; reset favours I on the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            last_d_q <= 1'b1;
        end else if (state_q == ST_IDLE && any_req_c) begin
            last_d_q <= pick_d_c;
        end
    end
`else
    assign tie_pick_d_c = 1'b1;
`endif

    // Winner selection: a lone request wins outright, ties go through tie_pick_d_c.
    always_comb begin
        pick_d_c = i_dm_req;
        if (i_dm_req && i_ic_req) begin
            pick_d_c = tie_pick_d_c;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    state_d = pick_d_c ? ST_GNT_D : ST_GNT_I;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                if (i_mem_ack || timeout_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; memory-side fields hold between grants.
    always_comb begin
        mem_req_d   = o_mem_req;
        mem_we_d    = o_mem_we;
        mem_addr_d  = o_mem_addr;
        mem_wdata_d = o_mem_wdata;
        mem_be_d    = o_mem_be;
        ic_ready_d  = 1'b0;
        ic_data_d   = '0;
        ic_err_d    = 1'b0;
        dm_ready_d  = 1'b0;
        dm_rdata_d  = '0;
        dm_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    mem_req_d = 1'b1;
                    if (pick_d_c) begin
                        mem_we_d    = i_dm_we;
                        mem_addr_d  = i_dm_addr;
                        mem_wdata_d = i_dm_wdata;
                        mem_be_d    = i_dm_be;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_ic_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                    end
                end
            end
            ST_GNT_I: begin
                if (i_mem_ack) begin
                    mem_req_d  = 1'b0;
                    ic_ready_d = 1'b1;
                    ic_data_d  = i_mem_rdata;
                end else if (timeout_c) begin
                    mem_req_d  = 1'b0;
                    ic_ready_d = 1'b1;
                    ic_err_d   = 1'b1;
                end
            end
            ST_GNT_D: begin
                if (i_mem_ack) begin
                    mem_req_d  = 1'b0;
                    dm_ready_d = 1'b1;
                    dm_rdata_d = i_mem_rdata;
                end else if (timeout_c) begin
                    mem_req_d  = 1'b0;
                    dm_ready_d = 1'b1;
                    dm_err_d   = 1'b1;
                end
            end
            default: mem_req_d = 1'b0;
        endcase
    end

    // Output registers; reset abandons any transaction without a ready pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_be    <= '0;
            o_ic_ready  <= 1'b0;
            o_ic_data   <= '0;
            o_ic_err    <= 1'b0;
            o_dm_ready  <= 1'b0;
            o_dm_rdata  <= '0;
            o_dm_err    <= 1'b0;
        end else begin
            o_mem_req   <= mem_req_d;
            o_mem_we    <= mem_we_d;
            o_mem_addr  <= mem_addr_d;
            o_mem_wdata <= mem_wdata_d;
            o_mem_be    <= mem_be_d;
            o_ic_ready  <= ic_ready_d;
            o_ic_data   <= ic_data_d;
            o_ic_err    <= ic_err_d;
            o_dm_ready  <= dm_ready_d;
            o_dm_rdata  <= dm_rdata_d;
            o_dm_err    <= dm_err_d;
        end
    end

    // Grant-cycle counter: zero while idle, counts every grant cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule
